// File: rtl/csa_pkg.sv
// Shared helpers for the carry-save adder tree: ceil-log2 and Wallace depth.
package csa_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Rows left after one level of 3:2 counters: each full group of three becomes two.
   function automatic int next_rows(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   function automatic int rows_at(input int n, input int lvl);
      int r;
      r = n;
      for (int i = 0; i < lvl; i++) begin
         r = next_rows(r);
      end
      return r;
   endfunction

   function automatic int wallace_levels(input int n);
      int r;
      int lv;
      r = n;
      lv = 0;
      while (r > 2) begin
         r = next_rows(r);
         lv++;
      end
      return lv;
   endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: reduces three addends to a sum word and a carry word.
module csa_3to2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);

   assign sum = a ^ b ^ c;

   // Carry is pre-shifted; the bit pushed out of the top is never needed because the
   // final sum always fits in WIDTH bits.
   assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
                   (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                   (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/csa_tree_pipe.sv
// Three-stage multi-operand adder: extend, Wallace 3:2 reduction, carry-propagate add,
// with a global stall driven by the output handshake.
module csa_tree_pipe
   import csa_pkg::*;
#(
   parameter  int IN_N = 8,
   parameter  int W    = 32,
   localparam int OW   = W + clog2(IN_N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_N*W-1:0] in_vec_flat,
   input  logic              in_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OW-1:0]     out_sum,
   output logic              busy
);

   localparam int LV = wallace_levels(IN_N);
   localparam int EW = OW - W;

   logic          advance;
   logic          s1_valid_reg;
   logic          s2_valid_reg;
   logic          s3_valid_reg;
   logic [OW-1:0] ext [IN_N];
   logic [OW-1:0] s1_op_reg [IN_N];
   logic [OW-1:0] s2_sum_reg;
   logic [OW-1:0] s2_carry_reg;
   logic [OW-1:0] s3_sum_reg;

   assign advance   = !s3_valid_reg || out_ready;
   assign in_ready  = advance;
   assign out_valid = s3_valid_reg;
   assign out_sum   = s3_sum_reg;
   assign busy      = s1_valid_reg | s2_valid_reg | s3_valid_reg;

   for (genvar gi = 0; gi < IN_N; gi++) begin : g_ext
      logic [W-1:0] op;
      assign op      = in_vec_flat[gi*W +: W];
      assign ext[gi] = {{EW{in_signed & op[W-1]}}, op};
   end

   // Each level keeps its own row arrays so no single signal feeds back on itself.
   for (genvar gi = 0; gi < LV; gi++) begin : g_lvl
      localparam int N_CUR = rows_at(IN_N, gi);
      localparam int N_GRP = N_CUR / 3;
      localparam int N_REM = N_CUR % 3;
      localparam int N_NXT = 2 * N_GRP + N_REM;

      logic [OW-1:0] row_in  [IN_N];
      logic [OW-1:0] row_out [IN_N];

      if (gi == 0) begin : g_first
         assign row_in = s1_op_reg;
      end else begin : g_rest
         assign row_in = g_lvl[gi-1].row_out;
      end

      for (genvar gj = 0; gj < N_GRP; gj++) begin : g_csa
         csa_3to2 #(.WIDTH(OW)) u_csa (
            .a     (row_in[3*gj]),
            .b     (row_in[3*gj+1]),
            .c     (row_in[3*gj+2]),
            .sum   (row_out[2*gj]),
            .carry (row_out[2*gj+1])
         );
      end

      for (genvar gk = 0; gk < N_REM; gk++) begin : g_pass
         assign row_out[2*N_GRP+gk] = row_in[3*N_GRP+gk];
      end

      for (genvar gz = N_NXT; gz < IN_N; gz++) begin : g_zero
         assign row_out[gz] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s3_valid_reg <= 1'b0;
         s3_sum_reg   <= '0;
      end else if (advance) begin
         s1_valid_reg <= in_valid;
         s2_valid_reg <= s1_valid_reg;
         s3_valid_reg <= s2_valid_reg;
         s3_sum_reg   <= s2_sum_reg + s2_carry_reg;
      end
   end

   // Payload registers carry no reset; they are only meaningful alongside their valid bit.
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_op_reg    <= ext;
         s2_sum_reg   <= g_lvl[LV-1].row_out[0];
         s2_carry_reg <= g_lvl[LV-1].row_out[1];
      end
   end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: directed table, streaming, stall, reset and a parameter sweep.
module tb_csa_tree_pipe;

   localparam int N   = 8;
   localparam int WD  = 32;
   localparam int OWD = 35;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             in_signed;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic [N*WD-1:0]  in_vec;
   logic [OWD-1:0]   out_sum;

   int n_vec   = 0;
   int n_bad   = 0;
   int n_deliv = 0;
   logic [127:0] exp_q [$];

   csa_tree_pipe #(.IN_N(N), .W(WD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_vec_flat (in_vec),
      .in_signed   (in_signed),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .busy        (busy)
   );

   // Reference: add the operands as mathematical integers, then keep the low ow bits.
   function automatic logic [127:0] ref_sum(input logic [2047:0] v, input int n, input int w,
                                             input int ow, input logic sg);
      logic signed [127:0] acc;
      logic signed [127:0] e;
      logic [2047:0]       sh;
      logic [127:0]        mask;
      acc  = '0;
      mask = (128'd1 << w) - 128'd1;
      for (int i = 0; i < n; i++) begin
         sh = v >> (i * w);
         e  = $signed(sh[127:0] & mask);
         if (sg && e[w-1]) e = e - (128'sd1 <<< w);
         acc = acc + e;
      end
      return acc & ((128'd1 << ow) - 128'd1);
   endfunction

   function automatic logic [63:0] rand_op(input int w);
      logic [63:0] r;
      logic [63:0] mask;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      case ($urandom_range(0, 3))
         0:       r = 64'hFFFF_FFFF_FFFF_FFFF;
         1:       r = 64'd1 << (w - 1);
         2:       r = 64'd0 | $urandom_range(0, 3);
         default: r = {$urandom, $urandom};
      endcase
      return r & mask;
   endfunction

   function automatic logic [N*WD-1:0] rand_vec8();
      logic [N*WD-1:0] v;
      logic [63:0]     t;
      for (int i = 0; i < N; i++) begin
         t = rand_op(WD);
         v[i*WD +: WD] = t[WD-1:0];
      end
      return v;
   endfunction

   function automatic logic [N*WD-1:0] mk_vec(input int mode, input logic [31:0] a, input logic [31:0] b);
      logic [N*WD-1:0] v;
      for (int i = 0; i < N; i++) begin
         if (mode == 1) v[i*WD +: WD] = 32'(i + 1);
         else           v[i*WD +: WD] = (i % 2 == 0) ? a : b;
      end
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   task automatic fail(input string nm);
      n_vec++;
      n_bad++;
      $display("FAIL %s", nm);
   endtask

   // Scoreboard for the main instance: push on accept, pop and compare on deliver.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) fail("mon_unexpected_result");
            else begin
               $display("deliver sum=%0h", out_sum);
               check("mon_sum", 128'(out_sum), exp_q.pop_front());
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(ref_sum(2048'(in_vec), N, WD, OWD, in_signed));
      end
   end

   // Parameter sweep: independent instances with random backpressure and mixed signedness.
   for (genvar gs = 0; gs < 6; gs++) begin : g_sweep
      localparam int PN  = (gs < 2) ? 3 : ((gs < 4) ? 5 : 32);
      localparam int PW  = (gs % 2 == 1) ? 64 : 4;
      localparam int POW = PW + $clog2(PN);

      logic             s_rst_n;
      logic             s_in_valid;
      logic             s_in_ready;
      logic             s_in_signed;
      logic             s_out_valid;
      logic             s_out_ready;
      logic             s_busy;
      logic [PN*PW-1:0] s_vec;
      logic [POW-1:0]   s_sum;
      logic             done;
      logic [127:0]     s_q [$];

      csa_tree_pipe #(.IN_N(PN), .W(PW)) u_sw (
         .clk         (clk),
         .rst_n       (s_rst_n),
         .in_valid    (s_in_valid),
         .in_ready    (s_in_ready),
         .in_vec_flat (s_vec),
         .in_signed   (s_in_signed),
         .out_valid   (s_out_valid),
         .out_ready   (s_out_ready),
         .out_sum     (s_sum),
         .busy        (s_busy)
      );

      initial begin
         int          sent;
         int          got;
         logic [63:0] t;
         done        = 1'b0;
         sent        = 0;
         got         = 0;
         s_rst_n     = 1'b0;
         s_in_valid  = 1'b0;
         s_in_signed = 1'b0;
         s_out_ready = 1'b1;
         s_vec       = '0;
         repeat (2) @(posedge clk);
         #1 s_rst_n = 1'b1;
         for (int c = 0; c < 400 && got < 20; c++) begin
            s_in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
            for (int i = 0; i < PN; i++) begin
               t = rand_op(PW);
               s_vec[i*PW +: PW] = t[PW-1:0];
            end
            s_in_signed = 1'($urandom_range(0, 1));
            s_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_out_valid && s_out_ready) begin
               got++;
               if (s_q.size() == 0) fail($sformatf("sweep%0d_unexpected", gs));
               else begin
                  $display("sweep%0d n=%0d w=%0d sum=%0h", gs, PN, PW, s_sum);
                  check($sformatf("sweep%0d_sum", gs), 128'(s_sum), s_q.pop_front());
               end
            end
            if (s_in_valid && s_in_ready) begin
               s_q.push_back(ref_sum(2048'(s_vec), PN, PW, POW, s_in_signed));
               sent++;
            end
            @(posedge clk);
            #1;
         end
         check($sformatf("sweep%0d_count", gs), 128'(got), 128'(20));
         done = 1'b1;
      end
   end

   typedef struct {
      logic           sg;
      logic [31:0]    a;
      logic [31:0]    b;
      int             mode;
      logic [OWD-1:0] expv;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int sent;
      int got;
      int first_c;
      int d0;
      int stale;

      tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 35'h7_FFFF_FFF8};
      tbl[1] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 0, 35'h4_0000_0000};
      tbl[2] = '{1'b1, 32'h0,         32'h0,         1, 35'd36};
      tbl[3] = '{1'b0, 32'h0,         32'h0,         1, 35'd36};
      tbl[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 35'h7_FFFF_FFF8};
      tbl[5] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 35'h3_FFFF_FFF8};
      tbl[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 0, 35'h4_0000_0000};
      tbl[7] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 35'h7_FFFF_FFFC};
      tbl[8] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 35'h3_FFFF_FFFC};
      tbl[9] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 35'h0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      in_signed = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy",      128'(busy),      128'(0));
      check("rst_in_ready",  128'(in_ready),  128'(1));
      check("rst_out_sum",   128'(out_sum),   128'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed vectors, one at a time, with latency measured from the accepting edge.
      for (int i = 0; i < 10; i++) begin
         in_valid  = 1'b1;
         in_signed = tbl[i].sg;
         in_vec    = mk_vec(tbl[i].mode, tbl[i].a, tbl[i].b);
         @(negedge clk);
         check($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(1));
         @(posedge clk);
         #1 in_valid = 1'b0;
         for (lat = 1; lat < 10; lat++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
         end
         $display("tbl%0d signed=%0d sum=%0h latency=%0d", i, tbl[i].sg, out_sum, lat);
         check($sformatf("tbl%0d_latency", i), 128'(lat), 128'(3));
         check($sformatf("tbl%0d_sum", i), 128'(out_sum), 128'(tbl[i].expv));
         @(posedge clk);
         #1;
      end

      // 16 back-to-back vectors: results must come out on consecutive cycles.
      sent    = 0;
      got     = 0;
      first_c = -1;
      for (int c = 0; c < 40 && got < 16; c++) begin
         in_valid  = (sent < 16);
         in_signed = 1'($urandom_range(0, 1));
         in_vec    = rand_vec8();
         @(negedge clk);
         if (in_valid) begin
            check("b2b_in_ready", 128'(in_ready), 128'(1));
            sent++;
         end
         if (out_valid) begin
            if (first_c < 0) first_c = c;
            got++;
            check("b2b_slot", 128'(c - first_c), 128'(got - 1));
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("b2b_count",       128'(got),     128'(16));
      check("b2b_first_cycle", 128'(first_c), 128'(3));

      // Fill all three stages with the consumer stalled, hold, then drain.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid  = 1'b1;
         in_signed = 1'($urandom_range(0, 1));
         in_vec    = rand_vec8();
         @(negedge clk);
         check("stall_fill_ready", 128'(in_ready), 128'(1));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_in_ready",  128'(in_ready),  128'(0));
         check("stall_out_valid", 128'(out_valid), 128'(1));
         check("stall_busy",      128'(busy),      128'(1));
         if (exp_q.size() > 0) check("stall_out_sum", 128'(out_sum), exp_q[0]);
         else                  fail("stall_model_empty");
         @(posedge clk);
         #1;
      end
      d0        = n_deliv;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && n_deliv < d0 + 3; k++) @(posedge clk);
      #1;
      check("stall_drain_count", 128'(n_deliv - d0), 128'(3));
      check("stall_drain_idle",  128'(busy),         128'(0));

      // Reset with two vectors in flight, then a fresh vector on the first edge after release.
      for (int k = 0; k < 2; k++) begin
         in_valid  = 1'b1;
         in_signed = 1'($urandom_range(0, 1));
         in_vec    = rand_vec8();
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rstm_pre_valid", 128'(out_valid), 128'(1));
      #1 rst_n = 1'b0;
      #1;
      check("rstm_out_valid", 128'(out_valid), 128'(0));
      check("rstm_busy",      128'(busy),      128'(0));
      check("rstm_in_ready",  128'(in_ready),  128'(1));
      check("rstm_out_sum",   128'(out_sum),   128'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stale     = 0;
      in_valid  = 1'b1;
      in_signed = 1'b1;
      in_vec    = rand_vec8();
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("rstm_no_stale", 128'(stale), 128'(0));
      @(negedge clk);
      check("rstm_first_valid", 128'(out_valid), 128'(1));
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("rstm_tail_idle", 128'(stale), 128'(0));

      for (int k = 0; k < 3000; k++) begin
         if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
             g_sweep[3].done && g_sweep[4].done && g_sweep[5].done) break;
         @(posedge clk);
      end
      if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
            g_sweep[3].done && g_sweep[4].done && g_sweep[5].done))
         fail("sweep_timeout");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
